// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: owns the instruction-memory write port and loads a program
// from a byte stream. Bytes are packed big-endian into 32-bit words, each word
// is written to the next memory slot, and the pipeline is held in stall until
// the load ends with a one-cycle PC-restart pulse.
// Optional build macro IMEM_LOAD_CHECKSUM_EN adds an XOR checksum trailer word
// after the terminator and the checksum / checksum_ok outputs.
module imem_loader_ctrl #(
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] TERM_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              pc_restart,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum,
  output logic              checksum_ok
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         asm_q, asm_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                byte_ready_q, mem_we_q, cpu_stall_q, pc_restart_q, load_busy_q;
  logic                accept;
  logic [31:0]         word_next;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]         checksum_q, checksum_d;
  logic                checksum_ok_q, checksum_ok_d;
  logic                trailer_q, trailer_d;
`endif

  // Next-state and datapath update: byte assembly, word sequencing, termination
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    asm_d        = asm_q;
    word_idx_d   = word_idx_q;
    load_count_d = load_count_q;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    checksum_d    = checksum_q;
    checksum_ok_d = checksum_ok_q;
    trailer_d     = trailer_q;
`endif
    accept    = byte_valid && byte_ready_q;
    word_next = {asm_q[23:0], byte_data};

    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d      = S_LOAD;
          bcnt_d       = 2'd0;
          asm_d        = 32'd0;
          word_idx_d   = '0;
          load_count_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          checksum_d    = 32'd0;
          checksum_ok_d = 1'b0;
          trailer_d     = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (accept) begin
          asm_d  = word_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            // After the terminator one more word arrives: the expected checksum
            if (trailer_q) begin
              state_d       = S_DONE;
              checksum_ok_d = (word_next == checksum_q);
            end else if (word_next == TERM_WORD) begin
              trailer_d = 1'b1;
            end else begin
              state_d     = S_WRITE;
              mem_waddr_d = word_idx_q;
              mem_wdata_d = word_next;
            end
`else
            if (word_next == TERM_WORD) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_WRITE;
              mem_waddr_d = word_idx_q;
              mem_wdata_d = word_next;
            end
`endif
          end
        end
      end
      S_WRITE: begin
        word_idx_d   = word_idx_q + 1'b1;
        load_count_d = load_count_q + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        checksum_d   = checksum_q ^ mem_wdata_q;
`endif
        // A write into the last slot ends the load without a terminator
        state_d = (word_idx_q == LAST_IDX) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bcnt_q       <= 2'd0;
      asm_q        <= 32'd0;
      word_idx_q   <= '0;
      load_count_q <= '0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= 32'd0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_stall_q  <= 1'b0;
      pc_restart_q <= 1'b0;
      load_busy_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      checksum_q    <= 32'd0;
      checksum_ok_q <= 1'b0;
      trailer_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      word_idx_q   <= word_idx_d;
      load_count_q <= load_count_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= (state_d == S_LOAD);
      mem_we_q     <= (state_d == S_WRITE);
      cpu_stall_q  <= (state_d != S_IDLE);
      pc_restart_q <= (state_d == S_DONE);
      load_busy_q  <= (state_d != S_IDLE);
`ifdef IMEM_LOAD_CHECKSUM_EN
      checksum_q    <= checksum_d;
      checksum_ok_q <= checksum_ok_d;
      trailer_q     <= trailer_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_stall  = cpu_stall_q;
  assign pc_restart = pc_restart_q;
  assign load_busy  = load_busy_q;
  assign load_count = load_count_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign checksum    = checksum_q;
  assign checksum_ok = checksum_ok_q;
`endif

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Testbench for imem_loader_ctrl: random program streams with random byte
// gaps and stray start_load pulses, checked against a word-list model.
`timescale 1ns/1ps
module tb_imem_loader_ctrl;

  localparam int          DEPTH  = 256;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] TERM   = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_load = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready, mem_we, cpu_stall, pc_restart, load_busy;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   load_count;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]       checksum;
  logic              checksum_ok;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] stim[$];

  always #5 clk = ~clk;

  imem_loader_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TERM_WORD(TERM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_load (start_load),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .pc_restart (pc_restart),
    .load_busy  (load_busy),
    .load_count (load_count)
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    .checksum   (checksum),
    .checksum_ok(checksum_ok)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(3) == 0) w = TERM ^ (32'd1 << $urandom_range(31));
    if (w == TERM) w = 32'd0;
    return w;
  endfunction

  // Runs one load of the bytes in stim and checks it against the word-list model
  task automatic run_load(input int budget);
    logic [31:0] exp_w[$];
    logic [31:0] w, xsum;
    int          i, idx, wr, cyc;
    bit          term, done, acc, rdy_prev, exp_ok;
    exp_w.delete();
    i = 0; term = 0; xsum = 32'd0; exp_ok = 0;
    while (!term && exp_w.size() < DEPTH && i + 4 <= stim.size()) begin
      w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
      i += 4;
      if (w == TERM) term = 1;
      else begin
        exp_w.push_back(w);
        xsum ^= w;
      end
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    if (term && i + 4 <= stim.size()) begin
      w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
      i += 4;
      exp_ok = (w == xsum);
    end
`endif

    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    check_eq("busy_on", 64'({cpu_stall, load_busy, byte_ready, pc_restart}), 64'(4'b1110));
    check_eq("count_clr", 64'(load_count), 64'd0);

    idx = 0; wr = 0; done = 0; cyc = 0; rdy_prev = 0;
    while (!done && cyc < budget) begin
      acc = byte_valid && rdy_prev;
      if (acc) begin
        idx++;
        if (idx % 4 == 0 && (idx / 4 - 1) < exp_w.size())
          check_eq("we_latency", 64'(mem_we), 64'd1);
      end
      if (mem_we) begin
        if (wr < exp_w.size()) begin
          check_eq("waddr", 64'(mem_waddr), 64'(wr));
          check_eq("wdata", 64'(mem_wdata), 64'(exp_w[wr]));
        end else begin
          check_eq("extra_write", 64'(wr), 64'(exp_w.size()));
        end
        check_eq("rdy_in_write", 64'(byte_ready), 64'd0);
        wr++;
      end
      if (pc_restart) begin
        done = 1;
        check_eq("stall_in_done", 64'({cpu_stall, load_busy}), 64'(2'b11));
        check_eq("n_writes", 64'(wr), 64'(exp_w.size()));
        check_eq("bytes_taken", 64'(idx), 64'(i));
`ifdef IMEM_LOAD_CHECKSUM_EN
        check_eq("checksum", 64'(checksum), 64'(xsum));
        check_eq("checksum_ok", 64'(checksum_ok), 64'(exp_ok));
`endif
      end
      rdy_prev = byte_ready;
      if (acc || !byte_valid)
        byte_valid = (idx < stim.size()) && ($urandom_range(3) != 0);
      if (idx < stim.size()) byte_data = stim[idx];
      start_load = !done && load_busy && ($urandom_range(15) == 0);
      @(negedge clk);
      cyc++;
    end
    start_load = 1'b0;

    if (!done) begin
      check_eq("timeout", 64'd0, 64'd1);
      byte_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      check_eq("restart_pulse", 64'(pc_restart), 64'd0);
      check_eq("stall_off", 64'({cpu_stall, load_busy}), 64'd0);
      check_eq("load_count", 64'(load_count), 64'(exp_w.size()));
`ifdef IMEM_LOAD_CHECKSUM_EN
      check_eq("cs_ok_hold", 64'(checksum_ok), 64'(exp_ok));
`endif
      // Leftover bytes must stay with the upstream
      byte_valid = (idx < stim.size());
      repeat (2) begin
        @(negedge clk);
        check_eq("rdy_idle", 64'(byte_ready), 64'd0);
        check_eq("count_hold", 64'(load_count), 64'(exp_w.size()));
      end
    end
    byte_valid = 1'b0;
    stim.delete();
  endtask

  initial begin
    logic [31:0] xs;
    int          nw;
    #12;
    check_eq("rst_outputs", 64'({byte_ready, mem_we, cpu_stall, pc_restart, load_busy, load_count}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of a word, then a clean load from slot 0
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0; byte_valid = 1'b1; byte_data = 8'hAB;
    @(negedge clk); byte_data = 8'hCD;
    @(negedge clk); byte_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_eq("rst_async", 64'({byte_ready, mem_we, cpu_stall, pc_restart, load_busy, load_count}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    push_word(32'h11223344);
    push_word(TERM);
`ifdef IMEM_LOAD_CHECKSUM_EN
    push_word(32'h11223344);
`endif
    run_load(200);

    // Basic program
    push_word(32'h20080005);
    push_word(32'h00000000);
    push_word(TERM);
`ifdef IMEM_LOAD_CHECKSUM_EN
    push_word(32'h20080005);
`endif
    run_load(300);

    // Terminator as first word
    push_word(TERM);
`ifdef IMEM_LOAD_CHECKSUM_EN
    push_word(32'h00000000);
`endif
    run_load(200);

`ifdef IMEM_LOAD_CHECKSUM_EN
    push_word(32'h00000001); push_word(32'h00000003); push_word(TERM); push_word(32'h00000002);
    run_load(300);
    push_word(32'h00000001); push_word(32'h00000003); push_word(TERM); push_word(32'h00000005);
    run_load(300);
`endif

    // Full memory, no terminator, with extra bytes that must not be taken
    for (int k = 0; k < DEPTH; k++) push_word(rand_word());
    push_word(32'h0BADF00D);
    push_word(TERM);
    run_load(12000);

    // Random programs
    for (int r = 0; r < 8; r++) begin
      nw = $urandom_range(12);
      xs = 32'd0;
      for (int k = 0; k < nw; k++) begin
        logic [31:0] w;
        w = rand_word();
        xs ^= w;
        push_word(w);
      end
      push_word(TERM);
`ifdef IMEM_LOAD_CHECKSUM_EN
      push_word(($urandom_range(1) == 0) ? xs : (xs ^ 32'h1));
`endif
      if ($urandom_range(1) == 0) push_word(rand_word());
      run_load(600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
